// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift command sequencer slice.
//   shift_width()  : data width for a given log2 width (W = 2**N)
//   shift_cmd_t    : command layout {data, shift, lr} at the default N
//   out_state_t    : output register state (OUT_EMPTY / OUT_FULL)
// No ports (package).
// ---------------------------------------------------------------------------
package shift_pkg;

  localparam int SHIFT_N_DEFAULT = 4;

  function automatic int shift_width(input int n);
    return 1 << n;
  endfunction

  localparam int SHIFT_W_DEFAULT = shift_width(SHIFT_N_DEFAULT);

  typedef struct packed {
    logic [SHIFT_W_DEFAULT-1:0] data;
    logic [SHIFT_N_DEFAULT-1:0] shift;
    logic                       lr;
  } shift_cmd_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/nbit_shift.sv
// ---------------------------------------------------------------------------
// nbit_shift
// Combinational logical barrel shifter, zero fill, no rotation.
// Ports:
//   data_i  [W-1:0] operand
//   shift_i [N-1:0] shift amount
//   lr_i            1 = left, 0 = right
//   data_o  [W-1:0] shifted result
// ---------------------------------------------------------------------------
module nbit_shift #(
  parameter  int N = 4,
  localparam int W = 1 << N
) (
  input  logic [W-1:0] data_i,
  input  logic [N-1:0] shift_i,
  input  logic         lr_i,
  output logic [W-1:0] data_o
);

  assign data_o = lr_i ? (data_i << shift_i) : (data_i >> shift_i);

endmodule

// File: rtl/shift_cmd_fifo.sv
// ---------------------------------------------------------------------------
// shift_cmd_fifo
// Command FIFO: storage, wrapping pointers, separately tracked occupancy.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush_i           clears pointers and level; overrides push/pop
//   push_i, pop_i     write / read strobes (ignored when full / empty)
//   wdata_i, rdata_o  write data / head entry
//   level_o           occupancy 0..DEPTH
//   full_o, empty_o   occupancy flags from registered state
// ---------------------------------------------------------------------------
module shift_cmd_fifo #(
  parameter  int WIDTH = 21,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointers are log2(DEPTH) bits and wrap on their own; level is kept
  // separately so full and empty are unambiguous.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; only the pointers decide what is live.
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// shift_cmd_sequencer
// Buffers shift commands in a FIFO, issues one per cycle through nbit_shift
// and holds the result in an output register with full backpressure.
// Optional macro SHIFT_SEQ_STATS_EN adds cmd_count / stall_count outputs.
// Ports:
//   clk, rst_n, flush             clock, sync active-low reset, sync clear
//   in_valid/in_ready             command handshake
//   in_data, in_shift, in_lr      operand, amount, 1 = left / 0 = right
//   out_valid/out_ready, out_data result handshake and data
//   level                         FIFO occupancy
//   cmd_count, stall_count        (SHIFT_SEQ_STATS_EN only) 32-bit counters
// ---------------------------------------------------------------------------
module shift_cmd_sequencer
  import shift_pkg::*;
#(
  parameter  int N     = SHIFT_N_DEFAULT,
  parameter  int DEPTH = 4,
  localparam int W     = shift_width(N),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [N-1:0]  in_shift,
  input  logic          in_lr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [LW-1:0] level
`ifdef SHIFT_SEQ_STATS_EN
  ,
  output logic [31:0]   cmd_count,
  output logic [31:0]   stall_count
`endif
);

  typedef struct packed {
    logic [W-1:0] data;
    logic [N-1:0] shift;
    logic         lr;
  } cmd_t;

  cmd_t         in_cmd, head_cmd;
  logic         fifo_full, fifo_empty;
  logic         push, pop;
  logic [W-1:0] shift_result;
  out_state_t   state_q, state_d;
  logic [W-1:0] out_data_q, out_data_d;

  assign in_cmd   = '{data: in_data, shift: in_shift, lr: in_lr};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  // The output register can take a new result when empty or being drained.
  assign pop      = !fifo_empty && ((state_q == OUT_EMPTY) || out_ready);

  shift_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_cmd),
    .rdata_o (head_cmd),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  nbit_shift #(.N(N)) u_shift (
    .data_i  (head_cmd.data),
    .shift_i (head_cmd.shift),
    .lr_i    (head_cmd.lr),
    .data_o  (shift_result)
  );

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    if (pop) begin
      state_d    = OUT_FULL;
      out_data_d = shift_result;
    end else if (out_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  // flush empties the output stage but leaves the last data visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= OUT_EMPTY;
      out_data_q <= '0;
    end else if (flush) begin
      state_q    <= OUT_EMPTY;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_data  = out_data_q;

`ifdef SHIFT_SEQ_STATS_EN
  logic [31:0] cmd_count_q, stall_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cmd_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      if (push) cmd_count_q <= cmd_count_q + 32'd1;
      if (out_valid && !out_ready) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign cmd_count   = cmd_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
